// File: rtl/demux1to2_buffered.sv
// demux1to2_buffered: registered 1-to-2 word demux with a private FIFO per destination
module demux1to2_buffered #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     s_sel,
  output logic                     m0_valid,
  input  logic                     m0_ready,
  output logic [WIDTH-1:0]         m0_data,
  output logic [$clog2(DEPTH):0]   m0_count,
  output logic                     m1_valid,
  input  logic                     m1_ready,
  output logic [WIDTH-1:0]         m1_data,
  output logic [$clog2(DEPTH):0]   m1_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [2][DEPTH];
  logic [AW-1:0] wp [2];
  logic [AW-1:0] rp [2];
  logic [CW-1:0] cnt [2];
  logic [1:0] push;
  logic [1:0] pop;
  assign m0_valid = cnt[0] != '0;
  assign m1_valid = cnt[1] != '0;
  assign m0_data = mem[0][rp[0]];
  assign m1_data = mem[1][rp[1]];
  assign m0_count = cnt[0];
  assign m1_count = cnt[1];
  assign pop = {m1_valid && m1_ready, m0_valid && m0_ready};
  assign s_ready = rst_n && (cnt[s_sel] < CW'(DEPTH) || pop[s_sel]);
  assign push = {s_sel, !s_sel} & {2{s_valid && s_ready}};
  always_ff @(posedge clk) begin
    for (int x = 0; x < 2; x++) begin
      if (!rst_n) begin
        wp[x] <= '0;
        rp[x] <= '0;
        cnt[x] <= '0;
        for (int i = 0; i < DEPTH; i++) mem[x][i] <= '0;
      end else begin
        if (push[x]) begin
          mem[x][wp[x]] <= s_data;
          wp[x] <= wp[x] + AW'(1);
        end
        if (pop[x]) rp[x] <= rp[x] + AW'(1);
        cnt[x] <= cnt[x] + CW'(push[x]) - CW'(pop[x]);
      end
    end
  end
endmodule

// File: tb/tb_demux1to2_buffered.sv
// tb_demux1to2_buffered: directed vector bench for demux1to2_buffered
module tb_demux1to2_buffered;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [15:0] s_data = '0;
  logic s_sel = 1'b0;
  logic m0_valid, m1_valid;
  logic m0_ready = 1'b0;
  logic m1_ready = 1'b0;
  logic [15:0] m0_data, m1_data;
  logic [1:0] m0_count, m1_count;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  demux1to2_buffered #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sel(s_sel),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data), .m0_count(m0_count),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data), .m1_count(m1_count)
  );
  typedef struct {
    logic rn, v;
    logic [15:0] d;
    logic sel, r0, r1, srdy;
    logic [15:0] d0;
    logic [1:0] c0;
    logic [15:0] d1;
    logic [1:0] c1;
  } vec_t;
  vec_t tbl [22];
  function automatic vec_t mk(logic rn, logic v, logic [15:0] d, logic sel, logic r0, logic r1,
                              logic srdy, logic [15:0] d0, logic [1:0] c0, logic [15:0] d1, logic [1:0] c1);
    vec_t t;
    t.rn = rn; t.v = v; t.d = d; t.sel = sel; t.r0 = r0; t.r1 = r1; t.srdy = srdy;
    t.d0 = d0; t.c0 = c0; t.d1 = d1; t.c1 = c1;
    return t;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic pushed, popped;
  logic [15:0] pd;
  int sent, got, cyc;
  initial begin
    tbl[0]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);
    tbl[1]  = mk(1, 1, 16'h1100, 1, 0, 0, 1, 16'h0000, 0, 16'h1100, 1);
    tbl[2]  = mk(1, 0, 16'h0000, 0, 0, 1, 1, 16'h0000, 0, 16'h0000, 0);
    tbl[3]  = mk(1, 1, 16'hFFFF, 0, 0, 0, 1, 16'hFFFF, 1, 16'h0000, 0);
    tbl[4]  = mk(1, 1, 16'h1122, 1, 0, 0, 1, 16'hFFFF, 1, 16'h1122, 1);
    tbl[5]  = mk(1, 1, 16'h1111, 1, 0, 0, 1, 16'hFFFF, 1, 16'h1122, 2);
    tbl[6]  = mk(1, 1, 16'h2345, 0, 0, 0, 1, 16'hFFFF, 2, 16'h1122, 2);
    tbl[7]  = mk(1, 0, 16'h0000, 0, 1, 1, 1, 16'h2345, 1, 16'h1111, 1);
    tbl[8]  = mk(1, 0, 16'h0000, 0, 1, 1, 1, 16'h0000, 0, 16'h0000, 0);
    tbl[9]  = mk(1, 1, 16'h0A0A, 0, 0, 0, 1, 16'h0A0A, 1, 16'h0000, 0);
    tbl[10] = mk(1, 1, 16'h0B0B, 0, 0, 0, 1, 16'h0A0A, 2, 16'h0000, 0);
    tbl[11] = mk(1, 1, 16'h0C0C, 0, 0, 0, 0, 16'h0A0A, 2, 16'h0000, 0);
    tbl[12] = mk(1, 1, 16'h5432, 1, 0, 0, 1, 16'h0A0A, 2, 16'h5432, 1);
    tbl[13] = mk(1, 1, 16'hABCD, 0, 1, 0, 1, 16'h0B0B, 2, 16'h5432, 1);
    tbl[14] = mk(1, 0, 16'h0000, 0, 1, 1, 1, 16'hABCD, 1, 16'h0000, 0);
    tbl[15] = mk(1, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 0, 16'h0000, 0);
    tbl[16] = mk(1, 1, 16'h7001, 0, 0, 0, 1, 16'h7001, 1, 16'h0000, 0);
    tbl[17] = mk(1, 1, 16'h7002, 0, 0, 0, 1, 16'h7001, 2, 16'h0000, 0);
    tbl[18] = mk(1, 1, 16'h7003, 1, 0, 0, 1, 16'h7001, 2, 16'h7003, 1);
    tbl[19] = mk(0, 1, 16'h9999, 0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0);
    tbl[20] = mk(1, 1, 16'h8976, 0, 0, 0, 1, 16'h8976, 1, 16'h0000, 0);
    tbl[21] = mk(1, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 0, 16'h0000, 0);
    for (int k = 0; k < 22; k++) begin
      rst_n = tbl[k].rn; s_valid = tbl[k].v; s_data = tbl[k].d; s_sel = tbl[k].sel;
      m0_ready = tbl[k].r0; m1_ready = tbl[k].r1;
      #1;
      chk($sformatf("v%0d s_ready", k), 32'(s_ready), 32'(tbl[k].srdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d m0_count", k), 32'(m0_count), 32'(tbl[k].c0));
      chk($sformatf("v%0d m0_valid", k), 32'(m0_valid), 32'(tbl[k].c0 != 0));
      chk($sformatf("v%0d m1_count", k), 32'(m1_count), 32'(tbl[k].c1));
      chk($sformatf("v%0d m1_valid", k), 32'(m1_valid), 32'(tbl[k].c1 != 0));
      if (tbl[k].c0 != 0 || !tbl[k].rn) chk($sformatf("v%0d m0_data", k), 32'(m0_data), 32'(tbl[k].d0));
      if (tbl[k].c1 != 0 || !tbl[k].rn) chk($sformatf("v%0d m1_data", k), 32'(m1_data), 32'(tbl[k].d1));
    end
    sent = 0; got = 0; cyc = 0;
    while ((sent < 8 || got < 8) && cyc < 100) begin
      s_valid = sent < 8; s_data = 16'(sent + 1); s_sel = 1'b1;
      m0_ready = 1'b0; m1_ready = cyc[0];
      #1;
      pushed = s_valid && s_ready;
      popped = m1_valid && m1_ready;
      pd = m1_data;
      @(posedge clk);
      #1;
      if (popped) begin
        chk($sformatf("wrap pop %0d", got), 32'(pd), 32'(got + 1));
        got++;
      end
      if (pushed) sent++;
      cyc++;
    end
    s_valid = 1'b0; m1_ready = 1'b0;
    chk("wrap words out", 32'(got), 32'd8);
    chk("wrap m1_count", 32'(m1_count), 32'd0);
    chk("wrap m0_count", 32'(m0_count), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
